// File: rtl/histogram_frame_sequencer_if.sv
// rtl/histogram_frame_sequencer_if.sv - control/stream bundle between the frame sequencer and the filter+histogram top
interface histogram_frame_sequencer_if;
    logic [12:0] threshold;
    logic        init;
    logic        start;
    logic        fullImageDone;
    logic        readHistogram;
    logic [7:0]  xHistogramOut;
    logic [7:0]  yHistogramOut;
    logic        xValid;
    logic        yValid;
    logic        clearHistogram;
    logic        histogramCleared;

    modport master (
        output threshold, init, start, readHistogram, clearHistogram,
        input  fullImageDone, xHistogramOut, yHistogramOut, xValid, yValid, histogramCleared
    );

    modport slave (
        input  threshold, init, start, readHistogram, clearHistogram,
        output fullImageDone, xHistogramOut, yHistogramOut, xValid, yValid, histogramCleared
    );
endinterface

// File: rtl/histogram_frame_sequencer.sv
// rtl/histogram_frame_sequencer.sv - per-frame controller: init/start, wait filter, read and peak-track histograms, clear
module histogram_frame_sequencer #(
    parameter int NUM_BINS     = 256,
    parameter int FILT_TIMEOUT = 200000,
    parameter int RD_TIMEOUT   = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_req,
    input  logic [12:0]                   thr_cfg,
    histogram_frame_sequencer_if.master   dp,
    output logic                          busy,
    output logic                          result_valid,
    output logic [7:0]                    peak_x,
    output logic [7:0]                    peak_y,
    output logic [7:0]                    peak_x_cnt,
    output logic [7:0]                    peak_y_cnt,
    output logic                          timeout_err
);

    localparam int TMAX = (FILT_TIMEOUT > RD_TIMEOUT) ? FILT_TIMEOUT : RD_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] FILT_LAST = TW'(FILT_TIMEOUT - 1);
    localparam logic [TW-1:0] RD_LAST   = TW'(RD_TIMEOUT - 1);
    localparam logic [8:0]    BINS      = 9'(NUM_BINS);
    localparam logic [8:0]    BINS_M1   = 9'(NUM_BINS - 1);

    typedef enum logic [2:0] {
        IDLE, INIT, START, FILTER, READ, CLEAR, DONE
    } state_t;

    state_t          state, state_next;
    logic [TW-1:0]   timer;
    logic [8:0]      xbin, ybin;
    logic [12:0]     thr_reg;
    logic            init_r, start_r, read_r, clear_r;
    logic            to_hit;
    logic            x_last, y_last, x_take, y_take;

    assign dp.threshold      = thr_reg;
    assign dp.init           = init_r;
    assign dp.start          = start_r;
    assign dp.readHistogram  = read_r;
    assign dp.clearHistogram = clear_r;
    assign busy              = (state != IDLE);

    // An axis is finished once NUM_BINS beats are counted, including a final beat landing this cycle.
    assign x_take = (state == READ) && dp.xValid && (xbin != BINS);
    assign y_take = (state == READ) && dp.yValid && (ybin != BINS);
    assign x_last = (xbin == BINS) || (x_take && (xbin == BINS_M1));
    assign y_last = (ybin == BINS) || (y_take && (ybin == BINS_M1));

    always_comb begin
        state_next = state;
        to_hit     = 1'b0;
        unique case (state)
            IDLE:   if (frame_req) state_next = INIT;
            INIT:   state_next = START;
            START:  state_next = FILTER;
            FILTER: begin
                if (dp.fullImageDone) begin
                    state_next = READ;
                end else if (timer == FILT_LAST) begin
                    state_next = CLEAR;
                    to_hit     = 1'b1;
                end
            end
            READ: begin
                if (x_last && y_last) begin
                    state_next = CLEAR;
                end else if (timer == RD_LAST) begin
                    state_next = CLEAR;
                    to_hit     = 1'b1;
                end
            end
            CLEAR: begin
                if (dp.histogramCleared) begin
                    state_next = timeout_err ? IDLE : DONE;
                end else if (timer == RD_LAST) begin
                    state_next = IDLE;
                    to_hit     = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            xbin         <= '0;
            ybin         <= '0;
            thr_reg      <= '0;
            init_r       <= 1'b0;
            start_r      <= 1'b0;
            read_r       <= 1'b0;
            clear_r      <= 1'b0;
            result_valid <= 1'b0;
            peak_x       <= '0;
            peak_y       <= '0;
            peak_x_cnt   <= '0;
            peak_y_cnt   <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_next;
            init_r       <= (state_next == INIT);
            start_r      <= (state_next == START);
            read_r       <= (state_next == READ);
            clear_r      <= (state_next == CLEAR);
            result_valid <= (state_next == DONE);

            // Timer restarts on every state change, so each wait is measured from its own entry.
            if (state_next != state) begin
                timer <= '0;
            end else if (state == FILTER || state == READ || state == CLEAR) begin
                timer <= timer + 1'b1;
            end

            if (state == IDLE && frame_req) begin
                thr_reg     <= thr_cfg;
                peak_x      <= '0;
                peak_y      <= '0;
                peak_x_cnt  <= '0;
                peak_y_cnt  <= '0;
                timeout_err <= 1'b0;
            end

            if (to_hit) timeout_err <= 1'b1;

            if (state_next == READ && state != READ) begin
                xbin <= '0;
                ybin <= '0;
            end

            // Strict compare keeps the lowest index on ties.
            if (x_take) begin
                xbin <= xbin + 1'b1;
                if (dp.xHistogramOut > peak_x_cnt) begin
                    peak_x_cnt <= dp.xHistogramOut;
                    peak_x     <= xbin[7:0];
                end
            end
            if (y_take) begin
                ybin <= ybin + 1'b1;
                if (dp.yHistogramOut > peak_y_cnt) begin
                    peak_y_cnt <= dp.yHistogramOut;
                    peak_y     <= ybin[7:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_histogram_frame_sequencer.sv
// tb/tb_histogram_frame_sequencer.sv - randomized scoreboard bench for histogram_frame_sequencer
module tb_histogram_frame_sequencer;

    localparam int NB   = 256;
    localparam int FTO  = 120;
    localparam int RTO  = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_req;
    logic [12:0] thr_cfg;
    logic        busy, result_valid, timeout_err;
    logic [7:0]  peak_x, peak_y, peak_x_cnt, peak_y_cnt;

    histogram_frame_sequencer_if dp ();

    histogram_frame_sequencer #(
        .NUM_BINS(NB), .FILT_TIMEOUT(FTO), .RD_TIMEOUT(RTO)
    ) dut (
        .clk(clk), .reset(reset), .frame_req(frame_req), .thr_cfg(thr_cfg), .dp(dp.master),
        .busy(busy), .result_valid(result_valid), .peak_x(peak_x), .peak_y(peak_y),
        .peak_x_cnt(peak_x_cnt), .peak_y_cnt(peak_y_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int px, pxc, py, pyc, to, rv, thr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   passed = 0;
    int   xs[NB];
    int   ys[NB];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: highest value over the first n bins, lowest index holding it; zero histogram gives 0/0.
    task automatic peak_of(input bit axis_y, input int n, output int idx, output int cnt);
        cnt = 0;
        idx = 0;
        for (int i = 0; i < n; i++) begin
            int v;
            v = axis_y ? ys[i] : xs[i];
            if (v > cnt) cnt = v;
        end
        if (cnt != 0) begin
            for (int i = n - 1; i >= 0; i--) begin
                int v;
                v = axis_y ? ys[i] : xs[i];
                if (v == cnt) idx = i;
            end
        end
    endtask

    task automatic fill(input int pat);
        for (int i = 0; i < NB; i++) begin
            unique case (pat)
                0: begin xs[i] = 1; ys[i] = 1; end
                1: begin xs[i] = $urandom_range(0, 6); ys[i] = $urandom_range(0, 200); end
                2: begin xs[i] = 0; ys[i] = 0; end
                3: begin xs[i] = $urandom_range(0, 255); ys[i] = $urandom_range(0, 255); end
                default: begin xs[i] = $urandom_range(0, 254); ys[i] = $urandom_range(0, 254); end
            endcase
        end
        if (pat == 0) begin xs[17] = 9; ys[200] = 5; end
        if (pat == 1) begin xs[3] = 7; xs[50] = 7; end
        if (pat == 4) begin xs[NB-1] = 255; ys[0] = 255; end
    endtask

    // Monitor: latency checks on init/start, frame results compared when busy drops.
    bit prev_busy = 0, prev_init = 0, prev_req_idle = 0;
    int rv_cnt = 0;
    always @(negedge clk) begin
        if (reset) begin
            prev_busy = 0; prev_init = 0; prev_req_idle = 0; rv_cnt = 0;
        end else begin
            if (dp.init) begin
                chk("init_latency", prev_req_idle, 1);
                chk("init_clr_timeout", timeout_err, 0);
                chk("init_clr_peaks", peak_x | peak_y | peak_x_cnt | peak_y_cnt, 0);
            end
            if (dp.start) chk("start_after_init", prev_init, 1);
            if (result_valid) rv_cnt++;
            if (prev_busy && !busy) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("peak_x", peak_x, e.px);
                    chk("peak_x_cnt", peak_x_cnt, e.pxc);
                    chk("peak_y", peak_y, e.py);
                    chk("peak_y_cnt", peak_y_cnt, e.pyc);
                    chk("timeout_err", timeout_err, e.to);
                    chk("result_pulses", rv_cnt, e.rv);
                    chk("threshold", dp.threshold, e.thr);
                end
                rv_cnt = 0;
            end
            prev_busy = busy;
            prev_init = dp.init;
            prev_req_idle = frame_req && !busy;
        end
    end

    // kind: 0 normal, 1 filter timeout, 2 read timeout, 3 clear timeout, 4 reset mid-read
    task automatic run_frame(input int kind, input int thr, input int fdelay, input int ylag,
                             input bit gaps, input int stop_at, input bit req_in_read);
        exp_t e;
        int   n, xi, yi, c, xlim;
        bit   seen;

        @(posedge clk); #1;
        thr_cfg   = 13'(thr);
        frame_req = 1'b1;
        @(posedge clk); #1;
        frame_req = 1'b0;
        thr_cfg   = 13'($urandom);

        if (kind != 4) begin
            e.thr = thr & 'h1fff;
            if (kind == 1) begin
                e.px = 0; e.pxc = 0; e.py = 0; e.pyc = 0;
            end else begin
                peak_of(1'b0, (kind == 2) ? stop_at : NB, e.px, e.pxc);
                peak_of(1'b1, NB, e.py, e.pyc);
            end
            e.to = (kind == 1 || kind == 2 || kind == 3) ? 1 : 0;
            e.rv = e.to ? 0 : 1;
            sb.push_back(e);
        end

        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = dp.start;
        end
        chk("wait_start", seen, 1);

        if (kind == 1) begin
            n = 0;
            seen = 0;
            while (!seen && n < FTO + 20) begin
                @(negedge clk);
                n++;
                seen = timeout_err;
            end
            chk("filter_timeout_cycle", n, FTO + 1);
        end else begin
            repeat (fdelay) @(posedge clk);
            #1 dp.fullImageDone = 1'b1;
            @(posedge clk); #1;
            dp.fullImageDone = 1'b0;
            chk("read_entry", dp.readHistogram, 1);

            xi = 0; yi = 0; c = 0;
            xlim = (kind == 2) ? stop_at : NB + 2;
            while ((xi < xlim || yi < NB) && c < 2000) begin
                if (kind == 4 && xi == 120) begin
                    dp.xValid = 1'b0;
                    dp.yValid = 1'b0;
                    reset = 1'b1;
                    break;
                end
                dp.xValid = 1'b0;
                dp.yValid = 1'b0;
                frame_req = req_in_read && (c == 10);
                if (xi < xlim && (!gaps || $urandom_range(0, 3) != 0)) begin
                    dp.xValid = 1'b1;
                    dp.xHistogramOut = (xi < NB) ? 8'(xs[xi]) : 8'hff;
                    xi++;
                end
                if (c >= ylag && yi < NB && (!gaps || $urandom_range(0, 2) != 0)) begin
                    dp.yValid = 1'b1;
                    dp.yHistogramOut = 8'(ys[yi]);
                    yi++;
                end
                @(posedge clk); #1;
                c++;
            end
            dp.xValid = 1'b0;
            dp.yValid = 1'b0;
            frame_req = 1'b0;

            if (kind == 4) begin
                @(posedge clk); #1;
                reset = 1'b0;
                chk("rst_read_low", dp.readHistogram, 0);
                chk("rst_busy", busy, 0);
                chk("rst_peaks", peak_x | peak_y | peak_x_cnt | peak_y_cnt, 0);
                chk("rst_timeout", timeout_err, 0);
                return;
            end
        end

        seen = 0;
        for (int i = 0; i < RTO + 50 && !seen; i++) begin
            @(negedge clk);
            seen = dp.clearHistogram;
        end
        chk("wait_clear", seen, 1);

        if (kind != 3) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk); #1 dp.histogramCleared = 1'b1;
            @(posedge clk); #1 dp.histogramCleared = 1'b0;
        end

        seen = 0;
        for (int i = 0; i < RTO + 20 && !seen; i++) begin
            @(negedge clk);
            seen = !busy;
        end
        chk("wait_idle", seen, 1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        frame_req = 1'b1;
        thr_cfg = 13'd99;
        dp.fullImageDone = 1'b0;
        dp.xHistogramOut = '0;
        dp.yHistogramOut = '0;
        dp.xValid = 1'b0;
        dp.yValid = 1'b0;
        dp.histogramCleared = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        frame_req = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_ctl", {dp.init, dp.start, dp.readHistogram, dp.clearHistogram, result_valid}, 0);
        chk("reset_threshold", dp.threshold, 0);
        chk("reset_peaks", peak_x | peak_y | peak_x_cnt | peak_y_cnt, 0);
        chk("reset_timeout", timeout_err, 0);
        @(posedge clk); #1;
        chk("reset_req_ignored", busy, 0);

        fill(0); run_frame(0, 40, 100, 0, 0, 0, 0);
        fill(1); run_frame(0, $urandom, 30, 4, 1, 0, 1);
        run_frame(1, $urandom, 0, 0, 0, 0, 0);
        fill(3); run_frame(0, $urandom, 10, 2, 1, 0, 0);
        fill(2); run_frame(0, $urandom, 5, 0, 1, 0, 0);
        fill(3); run_frame(2, $urandom, 5, 0, 0, 100, 0);
        fill(4); run_frame(3, $urandom, 7, 1, 1, 0, 0);
        fill(3); run_frame(4, $urandom, 3, 0, 0, 0, 0);
        fill(4); run_frame(0, $urandom, 50, 3, 1, 0, 0);
        fill(0); run_frame(0, 40, 100, 0, 0, 0, 0);

        repeat (5) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
